// File: rtl/pipe_stage_chain_pkg.sv
// Shared definitions for the elastic pipeline register chain: default sizes,
// the occupancy-count width helper and the stage-index type.
package pipe_stage_chain_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_STAGES = 4;

    // Stage index used by the chain and by the hazard/flush vector generators.
    typedef logic [7:0] stage_idx_t;

    // Number of bits needed to hold a count in the range 0..stages.
    function automatic int cnt_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_chain_slot.sv
// One pipeline slot: a valid bit plus payload register with load, hold and kill.
// Payload is written only when a valid entry arrives, so it stays 0 after reset
// until the first real entry lands.
module pipe_slot
    import pipe_stage_chain_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              kill,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic              valid_next_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A load replaces the slot contents, so a kill on the old entry is moot.
    always_comb begin
        valid_d = valid_q & ~kill;
        data_d  = data_q;
        if (load) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o      = valid_q;
    assign valid_next_o = valid_d;
    assign data_o       = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready pipeline chain with bubble collapse, global stall,
// per-stage flush and a registered occupancy count. Stage 0 is the youngest.
// Define PIPE_PERF_CNT_EN to add saturating stall-cycle and flush-kill counters.
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int STAGES = DEFAULT_STAGES,
    parameter int CNT_W  = cnt_width(STAGES)
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall_i,
    input  logic [STAGES-1:0] flush_i,
    output logic [CNT_W-1:0]  count_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       flush_kills_o
`endif
);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] lv;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] v_next;
    logic [DATA_W-1:0] d [STAGES];
    logic [CNT_W-1:0]  count_q, count_d;

    assign lv = v & ~flush_i;

    // Backward ready: a slot can take a new entry if it is empty/killed or
    // everything older than it is moving.
    always_comb begin
        rdy = '0;
        rdy[STAGES-1] = out_ready | ~lv[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            rdy[k] = rdy[k+1] | ~lv[k];
        end
    end

    assign load      = rdy & {STAGES{~stall_i}};
    assign in_ready  = rdy[0] & ~stall_i;
    assign out_valid = lv[STAGES-1] & ~stall_i;
    assign out_data  = d[STAGES-1];

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        logic              src_valid;
        logic [DATA_W-1:0] src_data;

        if (g == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = lv[g-1];
            assign src_data  = d[g-1];
        end

        pipe_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk          (CLOCK),
            .rst_n        (RESET),
            .load         (load[g]),
            .kill         (flush_i[g]),
            .valid_i      (src_valid),
            .data_i       (src_data),
            .valid_o      (v[g]),
            .valid_next_o (v_next[g]),
            .data_o       (d[g])
        );
    end

    always_comb begin
        count_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            count_d = count_d + CNT_W'(v_next[k]);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0]      stall_cycles_q, stall_cycles_d;
    logic [31:0]      flush_kills_q, flush_kills_d;
    logic [CNT_W-1:0] kills;
    logic [32:0]      kill_sum;

    // Kills are counted on the raw valid bits, so an empty slot flushed is free.
    always_comb begin
        kills = '0;
        for (int k = 0; k < STAGES; k++) begin
            kills = kills + CNT_W'(v[k] & flush_i[k]);
        end
        kill_sum      = {1'b0, flush_kills_q} + 33'(kills);
        flush_kills_d = kill_sum[32] ? 32'hFFFF_FFFF : kill_sum[31:0];

        stall_cycles_d = stall_cycles_q;
        if ((stall_i | (out_valid & ~out_ready)) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            stall_cycles_q <= '0;
            flush_kills_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_kills_q  <= flush_kills_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_kills_o  = flush_kills_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (STAGES=4, DATA_W=32) with an
// accept-tracking scoreboard and an independent output monitor.
module tb_pipe_stage_chain;

    localparam int DATA_W = 32;
    localparam int STAGES = 4;
    localparam int CNT_W  = 3;

    logic              CLOCK;
    logic              RESET;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              stall_i;
    logic [STAGES-1:0] flush_i;
    logic [CNT_W-1:0]  count_o;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0]       stall_cycles_o;
    logic [31:0]       flush_kills_o;
`endif

    pipe_stage_chain #(
        .DATA_W (DATA_W),
        .STAGES (STAGES)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .count_o   (count_o)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles_o (stall_cycles_o),
        .flush_kills_o  (flush_kills_o)
`endif
    );

    // clock / reset
    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    // scoreboard state
    logic [DATA_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int first_acc_cyc   = -1;
    int first_out_cyc   = -1;
    int sixth_out_cyc   = -1;
    int n_out           = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every accepted input is expected to come out, in order.
    always @(negedge CLOCK) begin
        if (RESET && in_valid && in_ready) begin
            exp_q.push_back(in_data);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
    end

    // monitor
    always @(negedge CLOCK) begin
        if (RESET && out_valid && out_ready) begin
            n_out++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            if (n_out == 6) sixth_out_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %h want none (cycle %0d)", out_data, cyc);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic push_until(input int n, input logic [31:0] base, input int max_cyc, output int got);
        got = 0;
        in_valid = 1'b1;
        for (int c = 0; c < max_cyc && got < n; c++) begin
            in_data = base + 32'(got);
            @(negedge CLOCK);
            if (in_ready) got++;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) step();
        repeat (4) step();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        @(negedge CLOCK);
        chk({tag, "_count"}, 32'(count_o), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
`ifdef PIPE_PERF_CNT_EN
        chk({tag, "_stall_cycles"}, stall_cycles_o, 32'd0);
        chk({tag, "_flush_kills"}, flush_kills_o, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int got;

    initial begin
        RESET     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        stall_i   = 1'b0;
        flush_i   = '0;
        repeat (3) step();
        RESET = 1'b1;
        chk_reset_state("reset");
        step();

        // Back-to-back stream, unobstructed.
        out_ready = 1'b1;
        push_until(6, 32'hA0, 6, got);
        chk("t1_accepted_in_6", 32'(got), 32'd6);
        drain("t1_drain");
        chk("t1_latency", 32'(first_out_cyc - first_acc_cyc), 32'd4);
        chk("t1_rate", 32'(sixth_out_cyc - first_out_cyc), 32'd5);

        // Backpressure until full, then release.
        out_ready = 1'b0;
        push_until(6, 32'hA0, 10, got);
        chk("t2_accepted", 32'(got), 32'd4);
        @(negedge CLOCK);
        chk("t2_full_in_ready", 32'(in_ready), 32'd0);
        chk("t2_full_count", 32'(count_o), 32'd4);
        step();
        in_valid  = 1'b1;
        in_data   = 32'hA4;
        out_ready = 1'b1;
        @(negedge CLOCK);
        chk("t2_release_out_valid", 32'(out_valid), 32'd1);
        chk("t2_release_out_data", out_data, 32'hA0);
        chk("t2_release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_data = 32'hA5;
        step();
        in_valid = 1'b0;
        drain("t2_drain");

        // Flush the two youngest of a full chain.
        out_ready = 1'b0;
        push_until(4, 32'hA0, 6, got);
        repeat (2) step();
        flush_i = 4'b0011;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        @(negedge CLOCK);
        chk("t3_flush_in_ready", 32'(in_ready), 32'd1);
        step();
        flush_i = '0;
        @(negedge CLOCK);
        chk("t3_flush_count", 32'(count_o), 32'd2);
        step();
        drain("t3_drain");

        // Global stall for 3 cycles mid-stream.
        out_ready = 1'b1;
        got = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 30 && got < 8; c++) begin
            stall_i = (c >= 3 && c < 6);
            in_data = 32'hB0 + 32'(got);
            @(negedge CLOCK);
            if (stall_i) begin
                chk("t4_stall_out_valid", 32'(out_valid), 32'd0);
                chk("t4_stall_in_ready", 32'(in_ready), 32'd0);
            end
            if (in_ready) got++;
            step();
        end
        in_valid = 1'b0;
        stall_i  = 1'b0;
        chk("t4_accepted", 32'(got), 32'd8);
        drain("t4_drain");

        // Flush the oldest entry while stalled.
        out_ready = 1'b0;
        push_until(4, 32'hA0, 6, got);
        repeat (2) step();
        stall_i = 1'b1;
        flush_i = 4'b1000;
        void'(exp_q.pop_front());
        @(negedge CLOCK);
        chk("t5_stall_out_valid", 32'(out_valid), 32'd0);
        chk("t5_pre_count", 32'(count_o), 32'd4);
        step();
        flush_i = '0;
        @(negedge CLOCK);
        chk("t5_post_count", 32'(count_o), 32'd3);
        step();
        stall_i = 1'b0;
        drain("t5_drain");

        // Reset while full overrides a pending handshake.
        out_ready = 1'b0;
        push_until(4, 32'hC0, 6, got);
        step();
        RESET    = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        exp_q.delete();
        step();
        RESET    = 1'b1;
        in_valid = 1'b0;
        chk_reset_state("t6");
        step();
        out_ready = 1'b1;
        repeat (6) step();
        chk("t6_no_stale", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
